sequence_filter_n: RTL

- Parametrised recursive moving-sum filter: y[n] = y[n-1] + x[n] - x[n-ORDER], i.e. the sum of the last ORDER accepted samples.
- Successor to the fixed two-term sequence block:
  - keeps its own delay line, so no external x_n_1 input;
  - adds a valid handshake, configurable width, depth and output saturation.
- Sits in the task_01_filter datapath between the sample source and downstream processing.

---
 rtl/sequence_filter_n.sv | 100 ++++++++++
 1 files changed

// File: rtl/sequence_filter_n.sv
// ============================================================================
// Module   : sequence_filter_n
// Brief    : Recursive moving-sum filter over the last ORDER accepted samples,
//            with valid handshake, run enable and optional output saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequence_filter_n #(
    parameter int WIDTH = 32,
    parameter int ORDER = 4,
    parameter int SAT   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable_start,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] x_n,
    output logic signed [WIDTH-1:0] y,
    output logic                    out_valid,
    output logic                    primed,
    output logic                    overflow
);

    localparam int ACC_W = WIDTH + $clog2(ORDER);
    localparam int CNT_W = $clog2(ORDER + 1);
    localparam int TOP_W = ACC_W - WIDTH + 1;
    localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(ORDER);

    logic signed [WIDTH-1:0] dl_q [ORDER];
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] w_x_ext, w_old_ext;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    out_valid_q, primed_q, overflow_q;
    logic                    w_accept, w_fits;
    logic [TOP_W-1:0]        w_top;

    assign w_accept  = enable_start & in_valid & ~reset;
    assign w_x_ext   = ACC_W'(x_n);
    assign w_old_ext = ACC_W'(dl_q[ORDER-1]);
    assign acc_d     = acc_q + w_x_ext - w_old_ext;

    // The value fits in WIDTH when every bit above the WIDTH sign bit copies it.
    assign w_top  = acc_d[ACC_W-1:WIDTH-1];
    assign w_fits = (&w_top) | ~(|w_top);

    generate
        if (SAT != 0) begin : g_sat
            always_comb begin
                y_d = acc_d[WIDTH-1:0];
                if (!w_fits) begin
                    y_d = acc_d[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
        end else begin : g_wrap
            assign y_d = acc_d[WIDTH-1:0];
        end
    endgenerate

    assign cnt_d = (cnt_q == C_CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < ORDER; k++) begin
                dl_q[k] <= '0;
            end
            acc_q       <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            primed_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            out_valid_q <= w_accept;
            if (w_accept) begin
                for (int k = ORDER - 1; k > 0; k--) begin
                    dl_q[k] <= dl_q[k-1];
                end
                dl_q[0]  <= x_n;
                acc_q    <= acc_d;
                y_q      <= y_d;
                cnt_q    <= cnt_d;
                primed_q <= (cnt_d == C_CNT_FULL);
                if (!w_fits) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;
    assign primed    = primed_q;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire
